// File: rtl/alu_sched.sv
// Round-robin scheduler that lets two requesters share one ALU instance.
// One operation is in flight at a time: the granted bundle is registered onto
// the ALU inputs, the result is sampled LATENCY cycles later and is then held
// on the response channel until the consumer accepts it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; the only state in which a grant is made
// EXEC  | ALU inputs driven from registers; cnt counts down to the sample
// RESP  | result held on rsp_* until rsp_valid && rsp_ready
module alu_sched #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [6+4*WIDTH-1:0]   req_bus0,
    input  logic [6+4*WIDTH-1:0]   req_bus1,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [2*WIDTH-1:0]     rsp_y,
    output logic [2:0]             alu_op,
    output logic                   alu_form,
    output logic [1:0]             alu_vec,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [WIDTH-1:0]       alu_c,
    output logic [WIDTH-1:0]       alu_d,
    input  logic [WIDTH-1:0]       alu_y1,
    input  logic [WIDTH-1:0]       alu_y2
);

    localparam int BW = 6 + 4 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic [BW-1:0]      bun_q, bun_d;
    logic               grant;

    // Grant selection, next-state logic and the combinational accept.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        bun_d       = bun_q;
        req_ready   = 2'b00;

        // A lone requester wins outright; under contention ptr decides.
        grant = ptr_q;
        if (req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!rst && req_valid[grant]) begin
                    req_ready[grant] = 1'b1;
                    bun_d            = grant ? req_bus1 : req_bus0;
                    rsp_id_d         = grant;
                    ptr_d            = ~grant;
                    cnt_d            = 4'(LATENCY);
                    state_d          = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_y_d     = {alu_y1, alu_y2};
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            bun_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            bun_q       <= bun_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign alu_op    = bun_q[BW-1 -: 3];
    assign alu_form  = bun_q[BW-4];
    assign alu_vec   = bun_q[BW-5 -: 2];
    assign alu_a     = bun_q[4*WIDTH-1 -: WIDTH];
    assign alu_b     = bun_q[3*WIDTH-1 -: WIDTH];
    assign alu_c     = bun_q[2*WIDTH-1 -: WIDTH];
    assign alu_d     = bun_q[WIDTH-1:0];

endmodule
